// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin owner of the single-ported data memory, core load/store (port 0) vs loader/DMA (port 1).
// Define DMEM_ARB_BURST_EN to let a locked owner hold the memory for up to BURST_MAX consecutive transfers.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic [1:0]    r0_we,
    input  logic [2:0]    r0_re,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic          r0_lock,
    output logic          r0_gnt,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_rvalid,
    input  logic          r1_req,
    input  logic [1:0]    r1_we,
    input  logic [2:0]    r1_re,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    input  logic          r1_lock,
    output logic          r1_gnt,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_rvalid,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic [1:0]    mem_we,
    output logic [2:0]    mem_re,
    input  logic [DW-1:0] mem_rd
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_t;

    own_t state, state_nx, owner_nx;
    logic last_p1, last_p1_nx;   // most recently served port was port 1
    logic xfer0, xfer1;

    assign r0_gnt = (state == OWN0);
    assign r1_gnt = (state == OWN1);
    assign xfer0  = r0_req && r0_gnt;
    assign xfer1  = r1_req && r1_gnt;

    // Stage p0: memory bus driven straight from the transferring port's payload
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 2'b00;
        mem_re = 3'b000;
        if (xfer0) begin
            mem_a  = r0_addr;
            mem_wd = r0_wdata;
            mem_we = r0_we;
            mem_re = r0_re;
        end else if (xfer1) begin
            mem_a  = r1_addr;
            mem_wd = r1_wdata;
            mem_we = r1_we;
            mem_re = r1_re;
        end
    end

    // Round-robin decision sees the transfer happening at this same edge
    always_comb begin
        last_p1_nx = last_p1;
        state_nx   = IDLE;
        if (xfer0)
            last_p1_nx = 1'b0;
        else if (xfer1)
            last_p1_nx = 1'b1;
        case ({r1_req, r0_req})
            2'b01:   state_nx = OWN0;
            2'b10:   state_nx = OWN1;
            2'b11:   state_nx = last_p1_nx ? OWN0 : OWN1;
            default: state_nx = IDLE;
        endcase
    end

`ifdef DMEM_ARB_BURST_EN
    localparam int CW = $clog2(BURST_MAX + 1);

    logic [CW-1:0] burst_cnt, burst_cnt_nx, burst_inc;

    // A locked owner overrides round-robin until its run of locked transfers reaches BURST_MAX
    always_comb begin
        burst_inc    = (burst_cnt == CW'(BURST_MAX)) ? burst_cnt : burst_cnt + 1'b1;
        owner_nx     = state_nx;
        burst_cnt_nx = '0;
        if (xfer0 && r0_lock) begin
            if (burst_inc != CW'(BURST_MAX))
                owner_nx = OWN0;
            if (owner_nx == OWN0)
                burst_cnt_nx = burst_inc;
        end else if (xfer1 && r1_lock) begin
            if (burst_inc != CW'(BURST_MAX))
                owner_nx = OWN1;
            if (owner_nx == OWN1)
                burst_cnt_nx = burst_inc;
        end
    end
`else
    localparam int unused_burst_max = BURST_MAX;
    logic unused_lock;

    assign unused_lock = r0_lock ^ r1_lock;
    assign owner_nx    = state_nx;
`endif

    // Stage p1: owner state and registered read return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_p1   <= 1'b1;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
`ifdef DMEM_ARB_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            state     <= owner_nx;
            last_p1   <= last_p1_nx;
            r0_rvalid <= xfer0 && (r0_re != 3'b000);
            r1_rvalid <= xfer1 && (r1_re != 3'b000);
            if (xfer0 && (r0_re != 3'b000))
                r0_rdata <= mem_rd;
            if (xfer1 && (r1_re != 3'b000))
                r1_rdata <= mem_rd;
`ifdef DMEM_ARB_BURST_EN
            burst_cnt <= burst_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed reset/latency/order cases then random two-master traffic,
// a scoreboard of expected bus payloads and read data, and a word-wide memory behind the arbiter.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BM = 4;
`ifdef DMEM_ARB_BURST_EN
    localparam int WAIT_LIMIT = BM;
    int exp_lock[7] = '{0, 0, 0, 0, 1, 0, 1};
`else
    localparam int WAIT_LIMIT = 1;
    int exp_lock[7] = '{0, 1, 0, 1, 0, 0, 0};
`endif
    int exp_alt[6] = '{0, 1, 0, 1, 0, 1};

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [1:0]    we;
        logic [2:0]    re;
        logic [DW-1:0] rd;
    } xfer_t;

    logic          clk, rst;
    logic          r0_req, r0_lock, r0_gnt, r0_rvalid;
    logic [1:0]    r0_we;
    logic [2:0]    r0_re;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_lock, r1_gnt, r1_rvalid;
    logic [1:0]    r1_we;
    logic [2:0]    r1_re;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic [1:0]    mem_we;
    logic [2:0]    mem_re;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    xfer_t         exp_q [2][$];
    int            log_p[$];
    int            log_c[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            base;

    logic          pend [2];
    logic [DW-1:0] pend_d [2];
    logic [DW-1:0] last_rd [2];
    int            wait_cnt [2];
    logic          xf [2];
    xfer_t         e_mon;

    dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_re(r0_re), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_re(r1_re), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide memory: any nonzero write code stores the whole word; reads are combinational
    assign mem_rd = mem[mem_a[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        forever begin
            @(posedge clk);
            if (mem_we != 2'b00) mem[mem_a[9:2]] <= mem_wd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? r0_gnt : r1_gnt;
    endfunction

    function automatic logic req_of(input int p);
        return (p == 0) ? r0_req : r1_req;
    endfunction

    task automatic drive(input int p, input logic rq, input logic [1:0] we, input logic [2:0] re,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic lk);
        if (p == 0) begin
            r0_req = rq; r0_we = we; r0_re = re; r0_addr = a; r0_wdata = wd; r0_lock = lk;
        end else begin
            r1_req = rq; r1_we = we; r1_re = re; r1_addr = a; r1_wdata = wd; r1_lock = lk;
        end
    endtask

    // Idle ports carry junk payload; the arbiter must keep it off the memory bus
    task automatic idle_port(input int p);
        drive(p, 1'b0, 2'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom));
    endtask

    task automatic issue(input int p, input logic [1:0] we, input logic [2:0] re,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic lk);
        xfer_t e;
        int idx;
        idx  = int'(a[9:2]);
        e.a  = a;
        e.wd = wd;
        e.we = we;
        e.re = re;
        e.rd = ref_mem[idx];
        if (we != 2'b00) ref_mem[idx] = wd;
        exp_q[p].push_back(e);
        drive(p, 1'b1, we, re, a, wd, lk);
    endtask

    task automatic wait_xfer(input int p);
        int w;
        w = 0;
        @(negedge clk);
        while (!gnt_of(p) && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("gnt_within_64_p%0d", p), gnt_of(p), 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input int p, input logic [1:0] we, input logic [2:0] re,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic lk);
        issue(p, we, re, a, wd, lk);
        wait_xfer(p);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Back-to-back transactions, each port in its own half of the memory
    task automatic seq(input int p, input int n, input logic lk);
        for (int i = 0; i < n; i++)
            run_txn(p, 2'($urandom), 3'($urandom), AW'((p * 128 + $urandom_range(0, 127)) * 4), $urandom, lk);
        idle_port(p);
    endtask

    task automatic rand_master(input int p, input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            run_txn(p, 2'($urandom), 3'($urandom), AW'((p * 128 + $urandom_range(0, 127)) * 4),
                    $urandom, 1'($urandom));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                idle_port(p);
                step(gap);
            end
        end
        idle_port(p);
    endtask

    task automatic chk_log(input string nm, input int idx, input int exp_p);
        chk(nm, (idx < log_p.size()) ? log_p[idx] : -1, exp_p);
    endtask

    // Scoreboard monitor: pops the expected payload on each transfer, checks the read return next cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_quiet_ctrl", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, mem_re}, '0);
            chk("rst_quiet_data", {mem_a, mem_wd, r0_rdata, r1_rdata}, '0);
            for (int p = 0; p < 2; p++) begin
                pend[p] = 1'b0; last_rd[p] = '0; wait_cnt[p] = 0;
            end
        end else begin
            chk("one_owner", r0_gnt & r1_gnt, 1'b0);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rvalid_p%0d", p), (p == 0) ? r0_rvalid : r1_rvalid, pend[p]);
                if (pend[p]) begin
                    chk($sformatf("rdata_p%0d", p), (p == 0) ? r0_rdata : r1_rdata, pend_d[p]);
                    last_rd[p] = pend_d[p];
                end else begin
                    chk($sformatf("rdata_hold_p%0d", p), (p == 0) ? r0_rdata : r1_rdata, last_rd[p]);
                end
            end
            xf[0] = r0_req && r0_gnt;
            xf[1] = r1_req && r1_gnt;
            if (!xf[0] && !xf[1])
                chk("bus_idle_zero", {mem_a, mem_wd, mem_we, mem_re}, '0);
            for (int p = 0; p < 2; p++) begin
                pend[p] = 1'b0;
                if (xf[p]) begin
                    if (exp_q[p].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_xfer_p%0d actual=transfer required=none", p);
                    end else begin
                        e_mon = exp_q[p].pop_front();
                        chk($sformatf("bus_payload_p%0d", p), {mem_a, mem_wd, mem_we, mem_re},
                            {e_mon.a, e_mon.wd, e_mon.we, e_mon.re});
                        pend[p]   = (e_mon.re != 3'b000);
                        pend_d[p] = e_mon.rd;
                    end
                    log_p.push_back(p);
                    log_c.push_back(cyc);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (req_of(p) && !xf[p]) begin
                    if (xf[1 - p]) begin
                        wait_cnt[p]++;
                        chk($sformatf("wait_bound_p%0d", p), wait_cnt[p] <= WAIT_LIMIT, 1'b1);
                    end
                end else begin
                    wait_cnt[p] = 0;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
        rst = 1'b0;
        idle_port(0);
        idle_port(1);

        // Reset held with port 0 already requesting a write
        issue(0, 2'b11, 3'b000, 32'h8, 32'hDEAD_BEEF, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_no_gnt_no_write", {r0_gnt, mem_we}, '0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("release_gnt_same_cycle", r0_gnt, 1'b0);
        @(negedge clk);
        chk("release_gnt_next_cycle", r0_gnt, 1'b1);
        chk("write_we", mem_we, 2'b11);
        chk("write_addr_data", {mem_a, mem_wd}, {32'h8, 32'hDEAD_BEEF});
        @(posedge clk); #1 idle_port(0);

        // Read back from idle: gnt at k+1, rvalid/rdata at k+2
        step(2);
        issue(0, 2'b00, 3'b010, 32'h8, $urandom, 1'b0);
        @(negedge clk);
        chk("rd_gnt_k", r0_gnt, 1'b0);
        @(negedge clk);
        chk("rd_gnt_k1", r0_gnt, 1'b1);
        @(posedge clk); #1 idle_port(0);
        @(negedge clk);
        chk("rd_rvalid_k2", r0_rvalid, 1'b1);
        chk("rd_rdata_k2", r0_rdata, 32'hDEAD_BEEF);

        // Reset in the cycle right after a read transfer
        @(posedge clk); #1;
        run_txn(0, 2'b00, 3'b001, 32'h4, $urandom, 1'b0);
        idle_port(0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", r0_rvalid, 1'b0);
        step(2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", {r0_gnt, r1_gnt}, '0);
        @(posedge clk); #1;

        // Both ports continuously requesting right after reset
        base = log_p.size();
        fork
            seq(0, 3, 1'b0);
            seq(1, 3, 1'b0);
        join
        for (int i = 0; i < 6; i++) chk_log($sformatf("alt_order_%0d", i), base + i, exp_alt[i]);

        // Port 1 sole requester: four back-to-back reads
        step(2);
        base = log_p.size();
        for (int i = 0; i < 4; i++) run_txn(1, 2'b00, 3'b100, AW'(i * 4), $urandom, 1'b0);
        idle_port(1);
        for (int i = 0; i < 4; i++) chk_log($sformatf("solo_port_%0d", i), base + i, 1);
        for (int i = 1; i < 4; i++)
            chk($sformatf("solo_consecutive_%0d", i),
                (base + i < log_c.size()) ? log_c[base + i] - log_c[base + i - 1] : -1, 1);

        // Port 0 locked against port 1
        step(2);
        base = log_p.size();
        fork
            seq(0, 5, 1'b1);
            seq(1, 2, 1'b0);
        join
        for (int i = 0; i < 7; i++) chk_log($sformatf("lock_order_%0d", i), base + i, exp_lock[i]);

        // Random traffic from both masters
        step(2);
        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join
        step(4);
        chk("drain_p0", exp_q[0].size(), 0);
        chk("drain_p1", exp_q[1].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
